// File: rtl/cs_branch_logic_pkg.sv
// Shared encodings for the microsequencer control-branch logic:
// COND field, next-address type, PSR bit positions and halt FSM states.
package cs_branch_logic_pkg;

    localparam logic [2:0] COND_NEXT    = 3'b000;
    localparam logic [2:0] COND_N       = 3'b001;
    localparam logic [2:0] COND_Z       = 3'b010;
    localparam logic [2:0] COND_V       = 3'b011;
    localparam logic [2:0] COND_C       = 3'b100;
    localparam logic [2:0] COND_IR13    = 3'b101;
    localparam logic [2:0] COND_JUMP    = 3'b110;
    localparam logic [2:0] COND_DECODE  = 3'b111;

    localparam logic [1:0] TIPO_NEXT    = 2'b00;
    localparam logic [1:0] TIPO_JUMP    = 2'b01;
    localparam logic [1:0] TIPO_DECODE  = 2'b10;

    localparam int unsigned PSR_N = 3;
    localparam int unsigned PSR_Z = 2;
    localparam int unsigned PSR_V = 1;
    localparam int unsigned PSR_C = 0;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

endpackage

// File: rtl/cs_branch_cond_eval.sv
// Pure combinational COND evaluation: COND x registered PSR x IR13 -> next-address type.
module cs_branch_cond_eval
    import cs_branch_logic_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic [3:0] i_psr,
    input  logic       i_ir13,
    output logic [1:0] o_tipo
);

    logic w_taken;

    always_comb begin
        w_taken = 1'b0;
        o_tipo  = TIPO_NEXT;
        case (i_cond)
            COND_NEXT:   w_taken = 1'b0;
            COND_N:      w_taken = i_psr[PSR_N];
            COND_Z:      w_taken = i_psr[PSR_Z];
            COND_V:      w_taken = i_psr[PSR_V];
            COND_C:      w_taken = i_psr[PSR_C];
            COND_IR13:   w_taken = i_ir13;
            COND_JUMP:   w_taken = 1'b1;
            default:     w_taken = 1'b0;
        endcase
        if (i_cond == COND_DECODE) begin
            o_tipo = TIPO_DECODE;
        end else if (w_taken) begin
            o_tipo = TIPO_JUMP;
        end
    end

endmodule

// File: rtl/cs_branch_logic.sv
// Control-branch logic: next-address type/jump/CSAI generation, PSR register,
// sticky self-loop halt detector and saturating microcycle counter.
module cs_branch_logic
    import cs_branch_logic_pkg::*;
#(
    parameter int unsigned DATAWIDTH_CSADDRESS = 11,
    parameter int unsigned DATAWIDTH_COND      = 3,
    parameter int unsigned DATAWIDTH_CBL       = 2,
    parameter int unsigned DATAWIDTH_CNT       = 16
) (
    input  logic                           CSADDRESS_CLOCK_50,
    input  logic                           CSADDRESS_ResetInHigh_In,
    input  logic [DATAWIDTH_CSADDRESS-1:0] CSBRANCH_CSAddress_InBus,
    input  logic [DATAWIDTH_COND-1:0]      CSBRANCH_Cond_InBus,
    input  logic [DATAWIDTH_CSADDRESS-1:0] CSBRANCH_JumpAddr_InBus,
    input  logic                           CSBRANCH_LoadCC_In,
    input  logic [3:0]                     CSBRANCH_AluFlags_InBus,
    input  logic                           CSBRANCH_IR13_In,
    output logic [DATAWIDTH_CBL-1:0]       CSBRANCH_Tipo_OutBus,
    output logic [DATAWIDTH_CSADDRESS-1:0] CSBRANCH_JumpAddress_OutBus,
    output logic [DATAWIDTH_CSADDRESS-1:0] CSBRANCH_CSAI_OutBus,
    output logic [3:0]                     CSBRANCH_Psr_OutBus,
    output logic                           CSBRANCH_Halt_Out,
    output logic [DATAWIDTH_CNT-1:0]       CSBRANCH_Count_OutBus
);

    logic [0:0]               r_state;
    logic [3:0]               r_psr;
    logic [DATAWIDTH_CNT-1:0] r_count;

    logic [0:0]               w_state_next;
    logic [1:0]               w_tipo_eval;
    logic                     w_halted;
    logic                     w_self_loop;
    logic                     w_cnt_sat;

    cs_branch_cond_eval u_cond_eval (
        .i_cond (CSBRANCH_Cond_InBus),
        .i_psr  (r_psr),
        .i_ir13 (CSBRANCH_IR13_In),
        .o_tipo (w_tipo_eval)
    );

    assign w_halted    = (r_state == ST_HALT);
    assign w_self_loop = (CSBRANCH_Cond_InBus == COND_JUMP) &&
                         (CSBRANCH_JumpAddr_InBus == CSBRANCH_CSAddress_InBus);
    assign w_cnt_sat   = (r_count == {DATAWIDTH_CNT{1'b1}});

    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_RUN && w_self_loop) begin
            w_state_next = ST_HALT;
        end
    end

    // Halted: spin on the current address so the sequencer stays frozen.
    always_comb begin
        if (w_halted) begin
            CSBRANCH_Tipo_OutBus        = TIPO_JUMP;
            CSBRANCH_JumpAddress_OutBus = CSBRANCH_CSAddress_InBus;
        end else begin
            CSBRANCH_Tipo_OutBus        = w_tipo_eval;
            CSBRANCH_JumpAddress_OutBus = CSBRANCH_JumpAddr_InBus;
        end
    end

    assign CSBRANCH_CSAI_OutBus  = CSBRANCH_CSAddress_InBus + DATAWIDTH_CSADDRESS'(1);
    assign CSBRANCH_Psr_OutBus   = r_psr;
    assign CSBRANCH_Halt_Out     = w_halted;
    assign CSBRANCH_Count_OutBus = r_count;

    always_ff @(posedge CSADDRESS_CLOCK_50 or posedge CSADDRESS_ResetInHigh_In) begin
        if (CSADDRESS_ResetInHigh_In) begin
            r_state <= ST_RUN;
            r_psr   <= 4'b0000;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (CSBRANCH_LoadCC_In && !w_halted) begin
                r_psr <= CSBRANCH_AluFlags_InBus;
            end
            if (!w_halted && !w_cnt_sat) begin
                r_count <= r_count + DATAWIDTH_CNT'(1);
            end
        end
    end

endmodule

// File: tb/tb_cs_branch_logic.sv
// Directed self-checking bench for cs_branch_logic.
module tb_cs_branch_logic;

    logic        clk;
    logic        rst;
    logic [10:0] cs_addr;
    logic [2:0]  cond;
    logic [10:0] jump_addr;
    logic        load_cc;
    logic [3:0]  alu_flags;
    logic        ir13;
    logic [1:0]  tipo;
    logic [10:0] jump_out;
    logic [10:0] csai;
    logic [3:0]  psr;
    logic        halt;
    logic [15:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    cs_branch_logic dut (
        .CSADDRESS_CLOCK_50          (clk),
        .CSADDRESS_ResetInHigh_In    (rst),
        .CSBRANCH_CSAddress_InBus    (cs_addr),
        .CSBRANCH_Cond_InBus         (cond),
        .CSBRANCH_JumpAddr_InBus     (jump_addr),
        .CSBRANCH_LoadCC_In          (load_cc),
        .CSBRANCH_AluFlags_InBus     (alu_flags),
        .CSBRANCH_IR13_In            (ir13),
        .CSBRANCH_Tipo_OutBus        (tipo),
        .CSBRANCH_JumpAddress_OutBus (jump_out),
        .CSBRANCH_CSAI_OutBus        (csai),
        .CSBRANCH_Psr_OutBus         (psr),
        .CSBRANCH_Halt_Out           (halt),
        .CSBRANCH_Count_OutBus       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        cs_addr   = 11'h010;
        cond      = 3'b000;
        jump_addr = 11'h000;
        load_cc   = 1'b0;
        alu_flags = 4'b0000;
        ir13      = 1'b0;
        #1;
        check("reset_tipo",  32'(tipo),  32'h0);
        check("reset_csai",  32'(csai),  32'h011);
        check("reset_psr",   32'(psr),   32'h0);
        check("reset_halt",  32'(halt),  32'h0);
        check("reset_count", 32'(count), 32'h0);
        #1 rst = 1'b0;

        tick();
        check("count_1", 32'(count), 32'd1);
        tick();
        check("count_2", 32'(count), 32'd2);

        // PSR load with same-cycle branch sees the old PSR
        load_cc   = 1'b1;
        alu_flags = 4'b0100;
        cond      = 3'b010;
        jump_addr = 11'h123;
        #1;
        check("z_old_psr_tipo", 32'(tipo), 32'h0);
        tick();
        load_cc = 1'b0;
        #1;
        check("psr_loaded",   32'(psr),      32'h4);
        check("count_3",      32'(count),    32'd3);
        check("z_taken_tipo", 32'(tipo),     32'h1);
        check("z_jump_addr",  32'(jump_out), 32'h123);

        cond = 3'b001; #1;
        check("n_untaken", 32'(tipo), 32'h0);
        cond = 3'b101; ir13 = 1'b0; #1;
        check("ir13_0", 32'(tipo), 32'h0);
        ir13 = 1'b1; #1;
        check("ir13_1", 32'(tipo), 32'h1);
        cond = 3'b111; #1;
        check("decode", 32'(tipo), 32'h2);
        cond = 3'b110; jump_addr = 11'h200; #1;
        check("uncond_jump", 32'(tipo), 32'h1);
        check("uncond_no_halt", 32'(halt), 32'h0);

        cond    = 3'b000;
        cs_addr = 11'h7FF;
        #1;
        check("csai_wrap", 32'(csai), 32'h000);
        check("next_tipo", 32'(tipo), 32'h0);
        tick();
        check("count_4", 32'(count), 32'd4);

        // Self-loop halt
        cond      = 3'b110;
        cs_addr   = 11'h040;
        jump_addr = 11'h040;
        #1;
        check("loop_tipo", 32'(tipo),     32'h1);
        check("loop_addr", 32'(jump_out), 32'h040);
        check("loop_halt_pre", 32'(halt), 32'h0);
        tick();
        check("halt_set",      32'(halt),  32'h1);
        check("count_detect",  32'(count), 32'd5);

        cond      = 3'b000;
        cs_addr   = 11'h050;
        jump_addr = 11'h123;
        load_cc   = 1'b1;
        alu_flags = 4'b1011;
        #1;
        check("halt_tipo", 32'(tipo),     32'h1);
        check("halt_addr", 32'(jump_out), 32'h050);
        tick();
        tick();
        check("halt_psr_frozen",   32'(psr),   32'h4);
        check("halt_count_frozen", 32'(count), 32'd5);
        check("halt_sticky",       32'(halt),  32'h1);

        load_cc = 1'b0;
        rst     = 1'b1;
        #1;
        check("rst_halt_clear",  32'(halt),  32'h0);
        check("rst_count_clear", 32'(count), 32'h0);
        check("rst_psr_clear",   32'(psr),   32'h0);
        check("rst_tipo",        32'(tipo),  32'h0);
        #1 rst = 1'b0;
        tick();
        check("post_rst_count", 32'(count), 32'd1);

        // Saturation: 65535 non-halted edges in total reach 0xFFFF
        repeat (65533) @(posedge clk);
        #1;
        check("count_fffe", 32'(count), 32'hFFFE);
        tick();
        check("count_ffff", 32'(count), 32'hFFFF);
        tick();
        tick();
        check("count_sat_hold", 32'(count), 32'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
